vram_blitter: RTL and testbench
===============================

Name: vram_blitter

Overview:
- Write-side engine for the double-buffered character frame buffer.
- Accepts rectangle-fill commands in cell coordinates on the 80x60 grid.
- Generates the byte write stream (a_wr/a_addr/a_din) into the back buffer, then optionally pulses commit to swap buffers.
- Sits between the CPU MMIO command registers and the frame buffer's write port, all in the a_clk domain.

Parameters:
COLS, 80, cells per row
ROWS, 60, rows per frame
ADDR_W, 13, frame buffer address width (COLS*ROWS = 4800 <= 2^13)
DATA_W, 8, cell byte width

Ports:
a_clk  in  1  clock (write-side clock of the frame buffer)
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid && cmd_ready at a rising edge
cmd_x0  in  7  left column
cmd_y0  in  6  top row
cmd_w  in  7  width in cells
cmd_h  in  6  height in rows
cmd_data  in  DATA_W  fill byte
cmd_commit  in  1  pulse commit after the fill
a_wr  out  1  frame buffer write strobe
a_addr  out  ADDR_W  cell address = y*COLS + x
a_din  out  DATA_W  write data
commit  out  1  one-cycle buffer swap request
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at command completion

Behaviour:
- Reset is rst, synchronous, active-high; clock is a_clk.
- Reset values: state IDLE; a_wr=0, a_addr=0, a_din=0, commit=0, done=0, busy=0, cmd_ready=1.
- Command capture: all cmd_* fields are registered on acceptance; later input changes are ignored.
- States: IDLE -> CLIP -> WRITE -> FIN -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On accept (edge T), go to CLIP.
- CLIP (cycle T+1), computes the clipped rectangle:
  - x1 = min(x0+w, COLS); y1 = min(y0+h, ROWS).
  - The command is empty if x0>=COLS, y0>=ROWS, w==0 or h==0.
  - Sums use 8-bit intermediates, so there is no wrap: x0=127, w=127 is empty.
  - Row base y0*COLS is loaded into a register.
  - Empty command: go directly to FIN.
  - Otherwise go to WRITE with x=x0, y=y0.
- WRITE:
  - One write per cycle: a_wr=1, a_addr=rowbase+x, a_din=data.
  - Outputs are registered; the first write is visible in cycle T+2.
  - x increments each cycle.
  - When x+1==x1: x=x0, y increments, rowbase+=COLS (incremental add, no multiplier in the loop).
  - After the write at (x1-1, y1-1), go to FIN.
  - Total writes = (x1-x0)*(y1-y0).
  - a_addr never exceeds COLS*ROWS-1.
- FIN (one cycle):
  - a_wr=0; done=1.
  - commit=1 iff the captured cmd_commit=1; this also applies to empty commands, so w=0 with cmd_commit=1 is a pure swap.
  - Next state IDLE.
- Timing: for N writes, the last write is in cycle T+1+N and done/commit in T+2+N. cmd_ready is back to 1 in T+3+N.
- Back-to-back commands: a new command can be accepted no earlier than the cycle after done. Writes of consecutive commands never interleave.
- a_wr is low in IDLE, CLIP and FIN. a_addr/a_din hold their last value when a_wr=0.
- Reset mid-operation: aborts immediately with no further writes and no commit/done pulse. Rectangle cells already written stay written.
- commit is never asserted in the same cycle as a_wr.

Decomposition:
- Shared package holds:
  - constants FB_COLS=80, FB_ROWS=60, FB_ADDR_W=13, FB_DATA_W=8 (shared with the frame buffer and display path);
  - the state enum {IDLE, CLIP, WRITE, FIN}.
- Optional sub-module rect_clip: combinational clip of x0/y0/w/h into x1/y1/empty. All sequencing stays in vram_blitter.

Test Plan:
1. Reset, then cmd x0=5, y0=2, w=1, h=1, data=0x41, commit=0 -> single write addr 165 data 0x41 at T+2; done at T+3; commit stays 0.
2. Full clear: x0=0, y0=0, w=80, h=60, data=0x20, commit=1 -> 4800 consecutive writes, addr 0..4799 in order; commit and done together at T+4802, one cycle each.
3. Right/bottom clip: x0=78, y0=59, w=10, h=5, data=0x7F -> exactly 2 writes, addr 4798 and 4799, then done.
4. Empty/commit-only: x0=90, w=4, h=4, commit=1 -> zero writes; commit=1 and done=1 at T+2; cmd_ready high at T+3.
5. Back-to-back: cmd_valid held high with two 3x2 commands -> cmd_ready low while busy; second accepted in the cycle after the first done; no overlap and no gap errors in the addresses.
6. Reset in WRITE: assert rst during the 10th write of a 20x1 fill -> a_wr=0 from the next cycle; no done, no commit; cmd_ready=1 after reset.

Source files
------------

// File: rtl/vram_blitter_pkg.sv
// Shared frame-buffer geometry and blitter sequencing states.
// Imported by the blitter, its clip helper, and the display path.
package vram_blitter_pkg;

  localparam int unsigned FB_COLS   = 80;
  localparam int unsigned FB_ROWS   = 60;
  localparam int unsigned FB_ADDR_W = 13;
  localparam int unsigned FB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    CLIP,
    WRITE,
    FIN
  } blit_state_e;

endpackage

// File: rtl/vram_blitter_rect_clip.sv
// Combinational clip of a fill rectangle against the character grid.
// Produces the exclusive right/bottom bounds and an empty flag.
module vram_blitter_rect_clip
  import vram_blitter_pkg::*;
#(
  parameter int unsigned COLS = FB_COLS,
  parameter int unsigned ROWS = FB_ROWS
) (
  input  logic [6:0] x0,
  input  logic [5:0] y0,
  input  logic [6:0] w,
  input  logic [5:0] h,
  output logic [6:0] x1,
  output logic [5:0] y1,
  output logic       empty
);

  logic [7:0] x_sum;
  logic [6:0] y_sum;

  // Widened sums so large origins plus large extents cannot wrap back on-screen.
  always_comb begin
    x_sum = {1'b0, x0} + {1'b0, w};
    y_sum = {1'b0, y0} + {1'b0, h};
    x1    = (x_sum > 8'(COLS)) ? 7'(COLS) : x_sum[6:0];
    y1    = (y_sum > 7'(ROWS)) ? 6'(ROWS) : y_sum[5:0];
    empty = (x0 >= 7'(COLS)) || (y0 >= 6'(ROWS)) || (w == 7'd0) || (h == 6'd0);
  end

endmodule

// File: rtl/vram_blitter.sv
// Rectangle-fill engine writing cell bytes into the back frame buffer,
// optionally followed by a one-cycle buffer swap request.
module vram_blitter
  import vram_blitter_pkg::*;
#(
  parameter int unsigned COLS   = FB_COLS,
  parameter int unsigned ROWS   = FB_ROWS,
  parameter int unsigned ADDR_W = FB_ADDR_W,
  parameter int unsigned DATA_W = FB_DATA_W
) (
  input  logic              a_clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [6:0]        cmd_x0,
  input  logic [5:0]        cmd_y0,
  input  logic [6:0]        cmd_w,
  input  logic [5:0]        cmd_h,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_commit,
  output logic              a_wr,
  output logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_din,
  output logic              commit,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ColsA = ADDR_W'(COLS);

  blit_state_e       state_q, state_d;
  logic [6:0]        x0_q, x0_d, w_q, w_d, x_q, x_d;
  logic [5:0]        y0_q, y0_d, h_q, h_d, y_q, y_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              cmt_q, cmt_d;
  logic [ADDR_W-1:0] rowbase_q, rowbase_d;
  logic              a_wr_q, a_wr_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [DATA_W-1:0] a_din_q, a_din_d;
  logic              commit_q, commit_d;
  logic              done_q, done_d;

  logic [6:0]        clip_x1;
  logic [5:0]        clip_y1;
  logic              clip_empty;
  logic [ADDR_W-1:0] row_init;

  // Captured fields are stable after acceptance, so the clip result is too.
  vram_blitter_rect_clip #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_clip (
    .x0    (x0_q),
    .y0    (y0_q),
    .w     (w_q),
    .h     (h_q),
    .x1    (clip_x1),
    .y1    (clip_y1),
    .empty (clip_empty)
  );

  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    w_d       = w_q;
    h_d       = h_q;
    data_d    = data_q;
    cmt_d     = cmt_q;
    x_d       = x_q;
    y_d       = y_q;
    rowbase_d = rowbase_q;
    a_wr_d    = 1'b0;
    a_addr_d  = a_addr_q;
    a_din_d   = a_din_q;
    commit_d  = 1'b0;
    done_d    = 1'b0;
    row_init  = ADDR_W'(y0_q) * ColsA;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          x0_d    = cmd_x0;
          y0_d    = cmd_y0;
          w_d     = cmd_w;
          h_d     = cmd_h;
          data_d  = cmd_data;
          cmt_d   = cmd_commit;
          state_d = CLIP;
        end
      end
      CLIP: begin
        if (clip_empty) begin
          state_d  = FIN;
          done_d   = 1'b1;
          commit_d = cmt_q;
        end else begin
          state_d   = WRITE;
          x_d       = x0_q;
          y_d       = y0_q;
          rowbase_d = row_init;
          a_wr_d    = 1'b1;
          a_addr_d  = row_init + ADDR_W'(x0_q);
          a_din_d   = data_q;
        end
      end
      WRITE: begin
        // x_q/y_q track the cell currently on the write port.
        if (x_q == clip_x1 - 7'd1) begin
          if (y_q == clip_y1 - 6'd1) begin
            state_d  = FIN;
            done_d   = 1'b1;
            commit_d = cmt_q;
          end else begin
            x_d       = x0_q;
            y_d       = y_q + 6'd1;
            rowbase_d = rowbase_q + ColsA;
            a_wr_d    = 1'b1;
            a_addr_d  = rowbase_q + ColsA + ADDR_W'(x0_q);
            a_din_d   = data_q;
          end
        end else begin
          x_d      = x_q + 7'd1;
          a_wr_d   = 1'b1;
          a_addr_d = rowbase_q + ADDR_W'(x_q) + ADDR_W'(1);
          a_din_d  = data_q;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge a_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      data_q    <= '0;
      cmt_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      rowbase_q <= '0;
      a_wr_q    <= 1'b0;
      a_addr_q  <= '0;
      a_din_q   <= '0;
      commit_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      w_q       <= w_d;
      h_q       <= h_d;
      data_q    <= data_d;
      cmt_q     <= cmt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      rowbase_q <= rowbase_d;
      a_wr_q    <= a_wr_d;
      a_addr_q  <= a_addr_d;
      a_din_q   <= a_din_d;
      commit_q  <= commit_d;
      done_q    <= done_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign a_wr      = a_wr_q;
  assign a_addr    = a_addr_q;
  assign a_din     = a_din_q;
  assign commit    = commit_q;
  assign done      = done_q;

endmodule

// File: tb/tb_vram_blitter.sv
// Bench for vram_blitter: per-cycle comparison against a rectangle-level model
// plus directed scenarios with hand-computed addresses and timings.
module tb_vram_blitter;

  logic        a_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [6:0]  cmd_x0 = '0;
  logic [5:0]  cmd_y0 = '0;
  logic [6:0]  cmd_w = '0;
  logic [5:0]  cmd_h = '0;
  logic [7:0]  cmd_data = '0;
  logic        cmd_commit = 1'b0;
  logic        a_wr;
  logic [12:0] a_addr;
  logic [7:0]  a_din;
  logic        commit;
  logic        busy;
  logic        done;

  vram_blitter dut (
    .a_clk      (a_clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x0     (cmd_x0),
    .cmd_y0     (cmd_y0),
    .cmd_w      (cmd_w),
    .cmd_h      (cmd_h),
    .cmd_data   (cmd_data),
    .cmd_commit (cmd_commit),
    .a_wr       (a_wr),
    .a_addr     (a_addr),
    .a_din      (a_din),
    .commit     (commit),
    .busy       (busy),
    .done       (done)
  );

  always #5 a_clk = ~a_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge a_clk) cyc <= cyc + 1;

  typedef struct {
    bit wr;
    int addr;
    int din;
    bit done;
    bit commit;
    bit busy;
    bit ready;
  } rec_t;

  rec_t q[$];
  rec_t cur;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Model: on acceptance, expand the whole command into its expected cycle trace.
  always @(posedge a_clk) begin : model_p
    int mx0, my0, mw, mh, mx1, my1, md;
    bit mc, mempty;
    rec_t r;
    if (rst) begin
      q.delete();
      cur = '{0, 0, 0, 0, 0, 0, 1};
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (cur.ready && cmd_valid) begin
      mx0 = int'(cmd_x0);
      my0 = int'(cmd_y0);
      mw  = int'(cmd_w);
      mh  = int'(cmd_h);
      md  = int'(cmd_data);
      mc  = cmd_commit;
      mx1 = imin(mx0 + mw, 80);
      my1 = imin(my0 + mh, 60);
      mempty = (mx0 >= 80) || (my0 >= 60) || (mw == 0) || (mh == 0);
      r = '{0, cur.addr, cur.din, 0, 0, 1, 0};
      q.push_back(r);
      if (!mempty) begin
        for (int y = my0; y < my1; y++) begin
          for (int x = mx0; x < mx1; x++) begin
            r = '{1, y * 80 + x, md, 0, 0, 1, 0};
            q.push_back(r);
          end
        end
      end
      r.wr = 0;
      r.done = 1;
      r.commit = mc;
      q.push_back(r);
      cur = q.pop_front();
    end else begin
      cur = '{0, cur.addr, cur.din, 0, 0, 0, 1};
    end
  end

  always @(negedge a_clk) begin
    if (chk_en) begin
      total++;
      if (a_wr !== cur.wr || a_addr !== 13'(cur.addr) || a_din !== 8'(cur.din) ||
          done !== cur.done || commit !== cur.commit || busy !== cur.busy ||
          cmd_ready !== cur.ready) begin
        bad++;
        $display("FAIL cycle %0d: got wr=%b addr=%0d din=%02h done=%b commit=%b busy=%b rdy=%b; need wr=%b addr=%0d din=%02h done=%b commit=%b busy=%b rdy=%b",
                 cyc, a_wr, a_addr, a_din, done, commit, busy, cmd_ready,
                 cur.wr, cur.addr, cur.din[7:0], cur.done, cur.commit, cur.busy, cur.ready);
      end
    end
  end

  int nwr, ndone, ncommit, first_wr_cyc, first_addr, first_din, last_addr;
  int done_cyc, commit_cyc, first_done_cyc;

  always @(negedge a_clk) begin
    if (a_wr === 1'b1) begin
      nwr++;
      if (nwr == 1) begin
        first_wr_cyc = cyc;
        first_addr = int'(a_addr);
        first_din = int'(a_din);
      end
      last_addr = int'(a_addr);
    end
    if (done === 1'b1) begin
      ndone++;
      done_cyc = cyc;
      if (ndone == 1) first_done_cyc = cyc;
    end
    if (commit === 1'b1) begin
      ncommit++;
      commit_cyc = cyc;
    end
  end

  task automatic clear_mon();
    nwr = 0; ndone = 0; ncommit = 0;
    first_wr_cyc = -1; first_addr = -1; first_din = -1; last_addr = -1;
    done_cyc = -1; commit_cyc = -1; first_done_cyc = -1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, need %0d", name, act, exp);
    end
  endtask

  task automatic send(input int x0, input int y0, input int w, input int h, input int d,
                      input bit c, input bit keep, output int t_acc);
    @(posedge a_clk); #1;
    cmd_x0 = 7'(x0);
    cmd_y0 = 6'(y0);
    cmd_w = 7'(w);
    cmd_h = 6'(h);
    cmd_data = 8'(d);
    cmd_commit = c;
    cmd_valid = 1'b1;
    t_acc = -1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge a_clk);
      if (cmd_ready === 1'b1) begin
        t_acc = cyc;
        break;
      end
    end
    if (t_acc < 0) begin
      total++;
      bad++;
      $display("FAIL accept timeout: got no cmd_ready, need acceptance");
    end
    @(posedge a_clk); #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge a_clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done timeout: got no done within %0d cycles", bound);
    end
    @(posedge a_clk); #1;
  endtask

  initial begin
    int ta, tb;
    clear_mon();
    repeat (3) @(posedge a_clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset cmd_ready", int'(cmd_ready), 1);
    check("reset busy", int'(busy), 0);
    check("reset a_wr/done/commit", int'({a_wr, done, commit}), 0);
    check("reset a_addr", int'(a_addr), 0);

    // Single cell
    clear_mon();
    send(5, 2, 1, 1, 'h41, 0, 0, ta);
    wait_done(50);
    check("t1 writes", nwr, 1);
    check("t1 addr", first_addr, 165);
    check("t1 data", first_din, 'h41);
    check("t1 first write cycle", first_wr_cyc, ta + 2);
    check("t1 done cycle", done_cyc, ta + 3);
    check("t1 commits", ncommit, 0);

    // Full clear with commit
    clear_mon();
    send(0, 0, 80, 60, 'h20, 1, 0, ta);
    wait_done(6000);
    check("t2 writes", nwr, 4800);
    check("t2 first addr", first_addr, 0);
    check("t2 last addr", last_addr, 4799);
    check("t2 done cycle", done_cyc, ta + 4802);
    check("t2 commit cycle", commit_cyc, ta + 4802);
    check("t2 commits", ncommit, 1);

    // Right/bottom clip
    clear_mon();
    send(78, 59, 10, 5, 'h7f, 0, 0, ta);
    wait_done(50);
    check("t3 writes", nwr, 2);
    check("t3 first addr", first_addr, 4798);
    check("t3 last addr", last_addr, 4799);
    check("t3 done cycle", done_cyc, ta + 4);

    // Off-screen commit-only
    clear_mon();
    send(90, 0, 4, 4, 'h00, 1, 0, ta);
    wait_done(50);
    check("t4 writes", nwr, 0);
    check("t4 done cycle", done_cyc, ta + 2);
    check("t4 commit cycle", commit_cyc, ta + 2);
    check("t4 ready after", int'(cmd_ready), 1);

    // Wide sums must not wrap
    clear_mon();
    send(127, 0, 127, 1, 'h11, 0, 0, ta);
    wait_done(50);
    check("wrap writes", nwr, 0);
    check("wrap dones", ndone, 1);

    // Back-to-back with cmd_valid held
    clear_mon();
    send(10, 3, 3, 2, 'h55, 0, 1, ta);
    send(20, 4, 3, 2, 'h66, 0, 0, tb);
    wait_done(50);
    check("t5 second accept", tb, ta + 9);
    check("t5 accept after done", tb, first_done_cyc + 1);
    check("t5 writes", nwr, 12);
    check("t5 dones", ndone, 2);
    check("t5 first addr", first_addr, 250);
    check("t5 last addr", last_addr, 422);

    // Reset during the 10th write
    clear_mon();
    send(0, 10, 20, 1, 'h33, 1, 0, ta);
    repeat (10) begin
      @(posedge a_clk); #1;
    end
    rst = 1'b1;
    @(posedge a_clk); #1;
    rst = 1'b0;
    check("t6 a_wr after reset", int'(a_wr), 0);
    repeat (5) begin
      @(posedge a_clk); #1;
    end
    check("t6 writes", nwr, 10);
    check("t6 last addr", last_addr, 809);
    check("t6 dones", ndone, 0);
    check("t6 commits", ncommit, 0);
    check("t6 ready", int'(cmd_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
